// File: rtl/seg_serial_rx_pkg.sv
// Shared constants and state type for the serial display-link receiver.
package seg_serial_rx_pkg;

  localparam int unsigned SEG_FRAME_BITS = 64;
  localparam int unsigned SEG_IDLE_TO    = 1024;

  // Pattern the display path drives onto a digit that should be dark.
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } seg_state_e;

endpackage

// File: rtl/seg_serial_rx_sync_edge.sv
// Two-flop synchroniser for a bundle of async inputs, with a rising-edge
// detector on bit 0.
module sync_edge #(
  parameter int unsigned          WIDTH   = 1,
  parameter logic [WIDTH-1:0]     RST_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o,
  output logic             rise_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;
  logic             dly_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      dly_q  <= RST_VAL[0];
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      dly_q  <= sync_q[0];
    end
  end

  assign q_o    = sync_q;
  assign rise_o = sync_q[0] & ~dly_q;

endmodule

// File: rtl/seg_serial_rx.sv
// Deserialiser for the SEGCLK/SEGDT display link: rebuilds each frame as a
// parallel word and flags frames cut short by an idle timeout.
module seg_serial_rx
  import seg_serial_rx_pkg::*;
#(
  parameter int unsigned FRAME_BITS = SEG_FRAME_BITS,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter int unsigned IDLE_TO    = SEG_IDLE_TO
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  ser_clk,
  input  logic                  ser_dat,
  input  logic                  ser_clr_n,
  input  logic                  ser_en,
  output logic [FRAME_BITS-1:0] frame_data,
  output logic                  frame_valid,
  output logic                  frame_err,
  output logic [6:0]            bit_cnt
);

  localparam int unsigned     TO_W     = $clog2(IDLE_TO);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(IDLE_TO - 1);
  localparam logic [6:0]      CNT_FULL = 7'(FRAME_BITS);

  logic sclk_sync_unused;
  logic sdat_sync;
  logic sclk_rise;
  logic clr_n_sync;
  logic clr_rise_unused;

  // Data rides in the same synchroniser as the clock so both are seen together.
  sync_edge #(
    .WIDTH   (2),
    .RST_VAL (2'b11)
  ) u_sync_clk_dat (
    .clk    (clk),
    .rst    (clr),
    .d_i    ({ser_dat, ser_clk}),
    .q_o    ({sdat_sync, sclk_sync_unused}),
    .rise_o (sclk_rise)
  );

  sync_edge #(
    .WIDTH   (1),
    .RST_VAL (1'b1)
  ) u_sync_clr (
    .clk    (clk),
    .rst    (clr),
    .d_i    (ser_clr_n),
    .q_o    (clr_n_sync),
    .rise_o (clr_rise_unused)
  );

  seg_state_e            state_q;
  logic [FRAME_BITS-1:0] sr_q;
  logic [FRAME_BITS-1:0] sr_d;
  logic [FRAME_BITS-1:0] data_q;
  logic [6:0]            cnt_q;
  logic [6:0]            cnt_inc;
  logic [TO_W-1:0]       to_q;
  logic                  valid_q;
  logic                  err_q;
  logic                  take;

  assign take    = sclk_rise & ser_en;
  assign cnt_inc = cnt_q + 7'd1;

  always_comb begin
    sr_d = sr_q;
    if (MSB_FIRST) begin
      sr_d = {sr_q[FRAME_BITS-2:0], sdat_sync};
    end else begin
      sr_d = {sdat_sync, sr_q[FRAME_BITS-1:1]};
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      to_q    <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else if (!clr_n_sync) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      to_q    <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          to_q <= '0;
          if (take) begin
            sr_q    <= sr_d;
            cnt_q   <= 7'd1;
            state_q <= (CNT_FULL == 7'd1) ? ST_DONE : ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (take) begin
            sr_q  <= sr_d;
            cnt_q <= cnt_inc;
            to_q  <= '0;
            if (cnt_inc == CNT_FULL) begin
              state_q <= ST_DONE;
            end
          end else if (to_q == TO_LAST) begin
            err_q   <= 1'b1;
            cnt_q   <= '0;
            to_q    <= '0;
            state_q <= ST_IDLE;
          end else begin
            to_q <= to_q + 1'b1;
          end
        end
        ST_DONE: begin
          // Publishes the pre-shift word, so a rise here opens the next frame intact.
          data_q  <= sr_q;
          valid_q <= 1'b1;
          to_q    <= '0;
          if (take) begin
            sr_q    <= sr_d;
            cnt_q   <= 7'd1;
            state_q <= ST_SHIFT;
          end else begin
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          to_q    <= '0;
        end
      endcase
    end
  end

  assign frame_data  = data_q;
  assign frame_valid = valid_q;
  assign frame_err   = err_q;
  assign bit_cnt     = cnt_q;

endmodule
